// File: rtl/toa_capture_if.sv
// rtl/toa_capture_if.sv - register port bundle between the I2C slave and toa_capture
//
// Purpose: groups the byte-wide register access signals so the host side
// (master) and the capture engine (slave) connect through one port.
//
// Signals:
//   addr        6  register address
//   write       1  one-cycle write strobe
//   write_data  8  write data
//   read        1  read strobe (reads have no side effects)
//   read_data   8  combinational read data from the engine

interface toa_capture_if;
  logic [5:0] addr;
  logic       write;
  logic [7:0] write_data;
  logic       read;
  logic [7:0] read_data;

  modport master (
    output addr,
    output write,
    output write_data,
    output read,
    input  read_data
  );

  modport slave (
    input  addr,
    input  write,
    input  write_data,
    input  read,
    output read_data
  );
endinterface

// File: rtl/toa_capture.sv
// rtl/toa_capture.sv - multi-channel time-of-arrival capture engine
//
// Purpose: conditions NCH microphone comparator inputs, starts a shared
// prescaled timebase on the first enabled arrival, latches one timestamp per
// channel and finishes on all-hit, timeout or timebase saturation.
//
// Parameters:
//   NCH       channel count (1..8)
//   CNT_W     timebase / timestamp width (9..16)
//   PRESCALE  clk cycles per timebase tick (>= 2)
//   FILT      consecutive high samples needed by the glitch filter (1..7)
//
// Ports:
//   clk       in   system clock (64 MHz)
//   reset_n   in   asynchronous active-low reset
//   mic       in   NCH raw asynchronous microphone/comparator inputs
//   bus       slave modport of toa_capture_if (addr/write/write_data/read/read_data)
//   done      out  high while the engine sits in DONE
//
// Build option: define TOA_GLITCH_FILTER_EN to insert the per-channel
// FILT-sample glitch filter between the synchroniser and the edge detector.
//
// Register map:
//   0x00 RO version 0x11
//   0x01 WO control {abort, arm}, self-clearing
//   0x02 RO status {4'b0, sat, tmo, state[1:0]}
//   0x03 RW enable mask
//   0x04 RO hit mask
//   0x05 RW timeout low byte, 0x06 RW timeout high byte
//   0x10+2i / 0x11+2i RO channel i stamp low/high

module toa_capture #(
  parameter int NCH      = 4,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 8,
  parameter int FILT     = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NCH-1:0] mic,
  toa_capture_if.slave   bus,
  output logic           done
);

  localparam int         PW      = $clog2(PRESCALE);
  localparam logic [7:0] VERSION = 8'h11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [NCH-1:0]   sync1, sync2;
  logic [NCH-1:0]   filt;
  logic [NCH-1:0]   prev;
  logic [NCH-1:0]   rise;
  logic [NCH-1:0]   cap_rise;
  logic [NCH-1:0]   hit;
  logic [NCH-1:0]   en;
  logic [CNT_W-1:0] tb;
  logic [CNT_W-1:0] tb_next;
  logic [CNT_W-1:0] timeout;
  logic [CNT_W-1:0] stamp [NCH];
  logic [PW-1:0]    pre;
  logic             pre_tick;
  logic             tb_max;
  logic             sat, tmo;
  logic             term_all, term_tmo, term_sat, term_any;
  logic             ctl_wr, arm, abort;
  logic [15:0]      to_ext, to_wr_lo, to_wr_hi;
  logic             unused_read;

  assign unused_read = bus.read;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchroniser and edge-detect history.
  // The history register follows the filtered level every cycle, so a line
  // that is already high when arm lands can never produce a rising edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= mic;
      sync2 <= sync1;
      prev  <= filt;
    end
  end

`ifdef TOA_GLITCH_FILTER_EN
  // Per-channel saturating run-length counter: the filtered level goes high on
  // the FILT-th consecutive high sample and drops on any low sample.
  logic [2:0] flt_cnt [NCH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt <= '0;
      for (int i = 0; i < NCH; i++) begin
        flt_cnt[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!sync2[i]) begin
          flt_cnt[i] <= 3'd0;
          filt[i]    <= 1'b0;
        end else begin
          if (flt_cnt[i] < 3'(FILT)) begin
            flt_cnt[i] <= flt_cnt[i] + 3'd1;
          end
          filt[i] <= (flt_cnt[i] >= 3'(FILT - 1));
        end
      end
    end
  end
`else
  localparam int unused_filt = FILT;

  assign filt = sync2;
`endif

  assign rise     = filt & ~prev & en;
  assign cap_rise = rise & ~hit;

  // ---------------------------------------------------------------------------
  // Timebase helpers. The prescaler restarts at 0 on CAPTURE entry, so the
  // first tick lands exactly PRESCALE cycles after entry.
  // ---------------------------------------------------------------------------
  assign pre_tick = (pre == PW'(PRESCALE - 1));
  assign tb_max   = &tb;
  assign tb_next  = (pre_tick && !tb_max) ? tb + CNT_W'(1) : tb;

  // Termination looks only at registered values, so done follows the final
  // hit or limit condition by one cycle.
  assign term_all = (hit == en);
  assign term_tmo = (timeout != '0) && (tb == timeout);
  assign term_sat = tb_max;
  assign term_any = term_all || term_tmo || term_sat;

  // ---------------------------------------------------------------------------
  // Write decode. Abort beats arm when both bits arrive in one write.
  // ---------------------------------------------------------------------------
  always_comb begin
    ctl_wr   = bus.write && (bus.addr == 6'h01);
    abort    = ctl_wr && bus.write_data[1];
    arm      = ctl_wr && bus.write_data[0] && !bus.write_data[1];
    to_ext   = 16'(timeout);
    to_wr_lo = {to_ext[15:8], bus.write_data};
    to_wr_hi = {bus.write_data, to_ext[7:0]};
  end

  // ---------------------------------------------------------------------------
  // Control FSM, timebase, hit mask, stamps and configuration registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      done    <= 1'b0;
      hit     <= '0;
      en      <= '1;
      timeout <= '0;
      tb      <= '0;
      pre     <= '0;
      sat     <= 1'b0;
      tmo     <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        stamp[i] <= '0;
      end
    end else begin
      if (bus.write && (bus.addr == 6'h03)) begin
        en <= bus.write_data[NCH-1:0];
      end
      if (bus.write && (bus.addr == 6'h05)) begin
        timeout <= to_wr_lo[CNT_W-1:0];
      end
      if (bus.write && (bus.addr == 6'h06)) begin
        timeout <= to_wr_hi[CNT_W-1:0];
      end

      if (abort) begin
        // Stamps are deliberately kept so the host can inspect a partial run.
        state <= IDLE;
        done  <= 1'b0;
        hit   <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (arm) begin
              state <= ARMED;
              done  <= 1'b0;
              hit   <= '0;
              tb    <= '0;
              pre   <= '0;
              sat   <= 1'b0;
              tmo   <= 1'b0;
              for (int i = 0; i < NCH; i++) begin
                stamp[i] <= '0;
              end
            end
          end

          ARMED: begin
            if (|rise) begin
              state <= CAPTURE;
              tb    <= '0;
              pre   <= '0;
              hit   <= rise;
              for (int i = 0; i < NCH; i++) begin
                if (rise[i]) begin
                  stamp[i] <= '0;
                end
              end
            end
          end

          CAPTURE: begin
            pre <= pre_tick ? '0 : pre + PW'(1);
            tb  <= tb_next;
            hit <= hit | cap_rise;
            // A channel stamps with the timebase value of the cycle its edge
            // is registered in, i.e. floor(cycles since entry / PRESCALE).
            for (int i = 0; i < NCH; i++) begin
              if (cap_rise[i]) begin
                stamp[i] <= tb_next;
              end else if (term_any && !hit[i]) begin
                stamp[i] <= '1;
              end
            end
            if (term_any) begin
              state <= DONE;
              done  <= 1'b1;
              tmo   <= term_tmo;
              sat   <= term_sat;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux (combinational, side-effect free). Stamps are zero-extended to
  // 16 bits so narrow builds still present a full low/high byte pair.
  // ---------------------------------------------------------------------------
  logic [15:0] s16;

  always_comb begin
    bus.read_data = 8'h00;
    s16           = 16'h0000;
    case (bus.addr)
      6'h00:   bus.read_data = VERSION;
      6'h02:   bus.read_data = {4'b0000, sat, tmo, state};
      6'h03:   bus.read_data = 8'(en);
      6'h04:   bus.read_data = 8'(hit);
      6'h05:   bus.read_data = to_ext[7:0];
      6'h06:   bus.read_data = to_ext[15:8];
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (bus.addr == 6'(16 + 2 * i)) begin
            s16           = 16'(stamp[i]);
            bus.read_data = s16[7:0];
          end else if (bus.addr == 6'(17 + 2 * i)) begin
            s16           = 16'(stamp[i]);
            bus.read_data = s16[15:8];
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_toa_capture.sv
// tb/tb_toa_capture.sv - self-checking scoreboard bench for toa_capture

module tb_toa_capture;

  localparam int NCH      = 4;
  localparam int CNT_W    = 16;
  localparam int PRESCALE = 8;
  localparam int FILT     = 3;
`ifdef TOA_GLITCH_FILTER_EN
  localparam int LAT = 3 + FILT;
`else
  localparam int LAT = 3;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [NCH-1:0] mic = '0;
  logic           done;

  toa_capture_if bus();

  toa_capture #(
    .NCH      (NCH),
    .CNT_W    (CNT_W),
    .PRESCALE (PRESCALE),
    .FILT     (FILT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mic     (mic),
    .bus     (bus),
    .done    (done)
  );

  always #8 clk = ~clk;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input logic [5:0] a, input logic [7:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_stamp(input int ch, input logic [15:0] v);
    push(6'(16 + 2 * ch), v[7:0]);
    push(6'(17 + 2 * ch), v[15:8]);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr       = a;
    bus.write_data = d;
    bus.write      = 1'b1;
    @(negedge clk);
    bus.write      = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.addr = a;
    bus.read = 1'b1;
    #1;
    d        = bus.read_data;
    bus.read = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic quiesce();
    mic = '0;
    repeat (LAT + 8) @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [7:0] got;
    bus.addr = 6'h00; bus.write = 1'b0; bus.write_data = 8'h00; bus.read = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b exp 0", done); end
    reset_n = 1'b1;
    push(6'h00, 8'h11); push(6'h02, 8'h00); push(6'h03, 8'h0F); push(6'h04, 8'h00);
    push(6'h01, 8'h00); push(6'h05, 8'h00); push(6'h06, 8'h00); push(6'h3F, 8'h00);
    for (int i = 0; i < NCH; i++) push_stamp(i, 16'h0000);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, got);
      total++;
      if (got !== e.data) begin bad++; $display("FAIL reset reg 0x%02h got 0x%02h exp 0x%02h", e.addr, got, e.data); end
    end
  endtask

  task automatic test_sequence();
    exp_t e;
    logic [7:0] got;
    int cyc;
    wr(6'h01, 8'h01);
    mic[2] = 1'b1; push_stamp(2, 16'd0);
    repeat (80) @(negedge clk);
    mic[0] = 1'b1; push_stamp(0, 16'd10);
    repeat (80) @(negedge clk);
    mic[1] = 1'b1; push_stamp(1, 16'd20);
    repeat (80) @(negedge clk);
    mic[3] = 1'b1; push_stamp(3, 16'd30);
    push(6'h02, 8'h03); push(6'h04, 8'h0F);
    wait_done(100, cyc);
    total++;
    if (cyc !== LAT + 1) begin bad++; $display("FAIL seq_done_latency got %0d exp %0d", cyc, LAT + 1); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, got);
      total++;
      if (got !== e.data) begin bad++; $display("FAIL seq reg 0x%02h got 0x%02h exp 0x%02h", e.addr, got, e.data); end
    end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL seq_done_hold got %b exp 1", done); end
    quiesce();
  endtask

  task automatic test_timeout();
    exp_t e;
    logic [7:0] got;
    int cyc;
    wr(6'h05, 8'h05);
    wr(6'h06, 8'h00);
    wr(6'h01, 8'h01);
    mic[1] = 1'b1;
    push(6'h02, 8'h07); push(6'h04, 8'h02);
    push_stamp(1, 16'h0000); push_stamp(0, 16'hFFFF);
    push_stamp(2, 16'hFFFF); push_stamp(3, 16'hFFFF);
    push(6'h05, 8'h05);
    wait_done(200, cyc);
    total++;
    if (cyc !== LAT + 5 * PRESCALE + 1) begin bad++; $display("FAIL tmo_done_latency got %0d exp %0d", cyc, LAT + 5 * PRESCALE + 1); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, got);
      total++;
      if (got !== e.data) begin bad++; $display("FAIL timeout reg 0x%02h got 0x%02h exp 0x%02h", e.addr, got, e.data); end
    end
    wr(6'h05, 8'h00);
    quiesce();
  endtask

  task automatic test_enable_mask();
    exp_t e;
    logic [7:0] got;
    int cyc;
    wr(6'h03, 8'h05);
    wr(6'h01, 8'h01);
    mic = 4'hF;
    push(6'h03, 8'h05); push(6'h04, 8'h05); push(6'h02, 8'h03);
    push_stamp(0, 16'h0000); push_stamp(2, 16'h0000);
    push_stamp(1, 16'hFFFF); push_stamp(3, 16'hFFFF);
    wait_done(50, cyc);
    total++;
    if (cyc !== LAT + 1) begin bad++; $display("FAIL mask_done_latency got %0d exp %0d", cyc, LAT + 1); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, got);
      total++;
      if (got !== e.data) begin bad++; $display("FAIL mask reg 0x%02h got 0x%02h exp 0x%02h", e.addr, got, e.data); end
    end
    wr(6'h03, 8'h0F);
    quiesce();
  endtask

  task automatic test_filter();
    exp_t e;
    logic [7:0] got;
    mic[3] = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    wr(6'h01, 8'h01);
`ifdef TOA_GLITCH_FILTER_EN
    mic[0] = 1'b1;
    repeat (2) @(negedge clk);
    mic[0] = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    push(6'h02, 8'h01); push(6'h04, 8'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, got);
      total++;
      if (got !== e.data) begin bad++; $display("FAIL glitch reg 0x%02h got 0x%02h exp 0x%02h", e.addr, got, e.data); end
    end
    mic[0] = 1'b1;
    repeat (3) @(negedge clk);
    mic[0] = 1'b0;
`else
    mic[0] = 1'b1;
    @(negedge clk);
    mic[0] = 1'b0;
`endif
    repeat (LAT + 4) @(negedge clk);
    push(6'h02, 8'h02); push(6'h04, 8'h01); push_stamp(0, 16'h0000);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, got);
      total++;
      if (got !== e.data) begin bad++; $display("FAIL filter reg 0x%02h got 0x%02h exp 0x%02h", e.addr, got, e.data); end
    end
    wr(6'h01, 8'h02);
    quiesce();
  endtask

  task automatic test_abort();
    exp_t e;
    logic [7:0] got;
    wr(6'h01, 8'h01);
    mic[1] = 1'b1; push_stamp(1, 16'd0);
    repeat (20) @(negedge clk);
    mic[2] = 1'b1; push_stamp(2, 16'd2);
    repeat (LAT + 4) @(negedge clk);
    wr(6'h01, 8'h01);
    rd(6'h02, got);
    total++;
    if (got !== 8'h02) begin bad++; $display("FAIL arm_in_capture status got 0x%02h exp 0x02", got); end
    wr(6'h01, 8'h03);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL abort_done got %b exp 0", done); end
    push(6'h02, 8'h00); push(6'h04, 8'h00); push_stamp(0, 16'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, got);
      total++;
      if (got !== e.data) begin bad++; $display("FAIL abort reg 0x%02h got 0x%02h exp 0x%02h", e.addr, got, e.data); end
    end
    quiesce();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [7:0] got;
    wr(6'h05, 8'h40);
    wr(6'h01, 8'h01);
    mic[0] = 1'b1;
    repeat (16) @(negedge clk);
    mic[1] = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    rd(6'h02, got);
    total++;
    if (got !== 8'h02) begin bad++; $display("FAIL pre_reset status got 0x%02h exp 0x02", got); end
    #3;
    reset_n = 1'b0;
    mic = '0;
    #1;
    total++;
    if (bus.read_data !== 8'h00) begin bad++; $display("FAIL async_reset status got 0x%02h exp 0x00", bus.read_data); end
    @(negedge clk);
    reset_n = 1'b1;
    push(6'h00, 8'h11); push(6'h02, 8'h00); push(6'h03, 8'h0F); push(6'h04, 8'h00);
    push(6'h05, 8'h00); push(6'h06, 8'h00);
    for (int i = 0; i < NCH; i++) push_stamp(i, 16'h0000);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, got);
      total++;
      if (got !== e.data) begin bad++; $display("FAIL reset_mid reg 0x%02h got 0x%02h exp 0x%02h", e.addr, got, e.data); end
    end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_mid_done got %b exp 0", done); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_timeout();
    test_enable_mask();
    test_filter();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
